// File: rtl/cpu_sequencer.sv
// Eight-phase instruction sequencer and control decoder for the 8-bit RISC CPU.
// A phase counter plus a sticky halted flag; every strobe is a combinational decode.
module cpu_sequencer #(
    parameter int OPCODE  = 3,
    parameter int PHASE_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPCODE-1:0]  opcode,
    input  logic               is_zero,
    output logic               sel,
    output logic               rd,
    output logic               ld_ir,
    output logic               inc_pc,
    output logic               ld_pc,
    output logic               ld_ac,
    output logic               wr,
    output logic               data_e,
    output logic               halt,
    output logic [PHASE_W-1:0] phase
);

    localparam logic [OPCODE-1:0] OP_HLT = OPCODE'(0);
    localparam logic [OPCODE-1:0] OP_SKZ = OPCODE'(1);
    localparam logic [OPCODE-1:0] OP_ADD = OPCODE'(2);
    localparam logic [OPCODE-1:0] OP_AND = OPCODE'(3);
    localparam logic [OPCODE-1:0] OP_XOR = OPCODE'(4);
    localparam logic [OPCODE-1:0] OP_LDA = OPCODE'(5);
    localparam logic [OPCODE-1:0] OP_STO = OPCODE'(6);
    localparam logic [OPCODE-1:0] OP_JMP = OPCODE'(7);

    typedef enum logic [PHASE_W-1:0] {
        INST_ADDR  = PHASE_W'(0),
        INST_FETCH = PHASE_W'(1),
        INST_LOAD  = PHASE_W'(2),
        IDLE       = PHASE_W'(3),
        OP_ADDR    = PHASE_W'(4),
        OP_FETCH   = PHASE_W'(5),
        ALU_OP     = PHASE_W'(6),
        STORE      = PHASE_W'(7)
    } phase_t;

    phase_t phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   aluop;
    logic   hlt_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    assign aluop   = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);
    assign hlt_now = (phase_q == OP_ADDR) && (opcode == OP_HLT);

    // A halted CPU parks in OP_FETCH; HLT reaches it naturally from OP_ADDR.
    always_comb begin
        halted_d = halted_q | (hlt_now & ~halted_q);
        if (halted_q) begin
            phase_d = OP_FETCH;
        end else begin
            phase_d = phase_t'(phase_q + PHASE_W'(1));
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = halted_q | hlt_now;
        if (!halted_q) begin
            case (phase_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                end
                OP_FETCH: begin
                    rd = aluop;
                end
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opcode == OP_SKZ) && is_zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opcode == OP_JMP);
                    wr     = (opcode == OP_STO);
                    data_e = (opcode == OP_STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-phase expectations queued, then popped and checked.
module tb_cpu_sequencer;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       is_zero;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0] phase;

    int total = 0;
    int bad   = 0;

    // Expected entry: {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt} and phase.
    typedef struct packed {
        logic [8:0] outs;
        logic [2:0] ph;
    } exp_t;
    exp_t sb[$];

    cpu_sequencer #(.OPCODE(3), .PHASE_W(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .is_zero(is_zero),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
        .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase masks (bit n = phase n) taken from the phase decode table.
    function automatic logic [8:0] expect_outs(input logic [2:0] op, input logic iz,
                                               input logic [2:0] ph);
        logic [7:0] m_sel, m_rd, m_ldir, m_inc, m_ldpc, m_ldac, m_wr, m_de, m_halt;
        logic       alu;
        alu    = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        m_sel  = 8'b0000_1111;
        m_ldir = 8'b0000_1100;
        m_rd   = 8'b0000_1110 | (alu ? 8'b1110_0000 : 8'b0);
        m_inc  = 8'b0001_0000 | ((op == 3'd1 && iz) ? 8'b0100_0000 : 8'b0);
        m_ldpc = (op == 3'd7) ? 8'b1100_0000 : 8'b0;
        m_ldac = alu ? 8'b1000_0000 : 8'b0;
        m_wr   = (op == 3'd6) ? 8'b1000_0000 : 8'b0;
        m_de   = (op == 3'd6) ? 8'b1100_0000 : 8'b0;
        m_halt = (op == 3'd0) ? 8'b0001_0000 : 8'b0;
        return {m_sel[ph], m_rd[ph], m_ldir[ph], m_inc[ph], m_ldpc[ph],
                m_ldac[ph], m_wr[ph], m_de[ph], m_halt[ph]};
    endfunction

    function automatic logic [8:0] observed();
        return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
    endfunction

    task automatic check_head(input string tag);
        exp_t e;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL %s: scoreboard empty", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            assert (observed() === e.outs) else begin
                bad++;
                $error("FAIL %s outs: got %b want %b", tag, observed(), e.outs);
            end
            total++;
            assert (phase === e.ph) else begin
                bad++;
                $error("FAIL %s phase: got %0d want %0d", tag, phase, e.ph);
            end
        end
    endtask

    // Called at a negedge with the DUT in phase 'first'; leaves it at the next negedge.
    task automatic run_phases(input string name, input logic [2:0] op, input logic iz,
                              input int first, input int n);
        logic [2:0] ph;
        opcode  = op;
        is_zero = iz;
        for (int k = 0; k < n; k++) begin
            ph = 3'((first + k) % 8);
            sb.push_back('{outs: expect_outs(op, iz, ph), ph: ph});
            #1;
            check_head($sformatf("%s ph%0d", name, ph));
            $display("txn %s op=%0d iz=%0b phase=%0d outs=%b", name, op, iz, ph, observed());
            if (k != n - 1) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        opcode  = 3'd0;
        is_zero = 1'b0;
        #12;
        sb.push_back('{outs: 9'b1_0000_0000, ph: 3'd0});
        check_head("reset_held");
        @(negedge clk);
        rst = 1'b0;

        run_phases("ADD",   3'd2, 1'b0, 0, 8); next_cycle();
        run_phases("SKZ_z", 3'd1, 1'b1, 0, 8); next_cycle();
        run_phases("SKZ_n", 3'd1, 1'b0, 0, 8); next_cycle();
        run_phases("AND",   3'd3, 1'b1, 0, 8); next_cycle();
        run_phases("XOR",   3'd4, 1'b0, 0, 8); next_cycle();
        run_phases("LDA",   3'd5, 1'b0, 0, 8); next_cycle();
        run_phases("JMP",   3'd7, 1'b1, 0, 8); next_cycle();
        run_phases("STO",   3'd6, 1'b0, 0, 8); next_cycle();

        // STO again, aborted by an asynchronous reset in the middle of phase 6.
        run_phases("STO_abort", 3'd6, 1'b0, 0, 7);
        #1 rst = 1'b1;
        #1;
        sb.push_back('{outs: 9'b1_0000_0000, ph: 3'd0});
        check_head("async_rst");
        $display("txn async_rst phase=%0d outs=%b", phase, observed());
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // HLT: halt rises in phase 4, then phase parks at 5 with only halt high.
        run_phases("HLT", 3'd0, 1'b0, 0, 5);
        for (int c = 0; c < 22; c++) begin
            next_cycle();
            opcode  = 3'(c);
            is_zero = c[0];
            sb.push_back('{outs: 9'b0_0000_0001, ph: 3'd5});
            #1;
            check_head($sformatf("halted c%0d", c));
            $display("txn halted c=%0d op=%0d phase=%0d outs=%b", c, opcode, phase, observed());
        end

        #1 rst = 1'b1;
        #1;
        sb.push_back('{outs: 9'b1_0000_0000, ph: 3'd0});
        check_head("unhalt_rst");
        @(negedge clk);
        rst = 1'b0;
        opcode = 3'd2;
        #1;
        sb.push_back('{outs: 9'b1_0000_0000, ph: 3'd0});
        check_head("after_unhalt");
        next_cycle();
        sb.push_back('{outs: expect_outs(3'd2, 1'b0, 3'd1), ph: 3'd1});
        #1;
        check_head("resume_ph1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: sim did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
